// File: rtl/stage2_unpooling_core.sv
// 2x2 nearest-neighbour unpooling core: each pooled point is emitted as a 2x2 block of output points.
// Optional macro ST2_UNPOOL_ZERO_FILL_EN selects zero-insertion unpooling and removes the row buffer.
module stage2_unpooling_core #(
    parameter int ST2_CI  = 3,
    parameter int ST2_IBW = 19,
    parameter int IN_W    = 12,
    parameter int IN_H    = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [ST2_CI*ST2_IBW-1:0]  i_in_fmap,
    output logic                       o_ot_valid,
    input  logic                       i_ot_ready,
    output logic [ST2_CI*ST2_IBW-1:0]  o_ot_fmap,
    output logic                       o_frame_done
);

    localparam int FW = ST2_CI * ST2_IBW;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;

    localparam logic [0:0] ROW_A = 1'b0;
    localparam logic [0:0] ROW_B = 1'b1;

`ifdef ST2_UNPOOL_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    logic [0:0]    state;
    logic [CW-1:0] col;
    logic [CW-1:0] col_inc;
    logic [RW-1:0] row;
    logic          dup;
    logic          last_col;
    logic          last_row;
    logic          ot_hs;
    logic          in_acc;
    logic [FW-1:0] buf_first;
    logic [FW-1:0] buf_next;

    assign col_inc  = col + CW'(1);
    assign last_col = (col == CW'(IN_W - 1));
    assign last_row = (row == RW'(IN_H - 1));
    assign ot_hs    = o_ot_valid && i_ot_ready;

    // The final column's second copy hands over to ROW_B, so no next-row point may be taken then.
    assign o_in_ready = !reset && (state == ROW_A) &&
                        (!o_ot_valid || (i_ot_ready && dup && !last_col));
    assign in_acc     = i_in_valid && o_in_ready;

`ifdef ST2_UNPOOL_ZERO_FILL_EN
    assign buf_first = '0;
    assign buf_next  = '0;
`else
    logic [FW-1:0] rowbuf [IN_W];
    logic [CW-1:0] wr_col;

    // An accept that overlaps the second copy's handshake belongs to the next column.
    assign wr_col = (ot_hs && dup) ? col_inc : col;

    always_ff @(posedge clk) begin
        if (in_acc) begin
            rowbuf[wr_col] <= i_in_fmap;
        end
    end

    assign buf_first = rowbuf[0];
    assign buf_next  = rowbuf[col_inc];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ROW_A;
            col          <= '0;
            row          <= '0;
            dup          <= 1'b0;
            o_ot_valid   <= 1'b0;
            o_ot_fmap    <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= 1'b0;
            case (state)
                ROW_A: begin
                    if (ot_hs) begin
                        if (!dup) begin
                            dup <= 1'b1;
                            if (ZERO_FILL) begin
                                o_ot_fmap <= '0;
                            end
                        end else if (last_col) begin
                            col       <= '0;
                            dup       <= 1'b0;
                            o_ot_fmap <= buf_first;
                            state     <= ROW_B;
                        end else begin
                            col <= col_inc;
                            if (!in_acc) begin
                                o_ot_valid <= 1'b0;
                            end
                        end
                    end
                    if (in_acc) begin
                        o_ot_fmap  <= i_in_fmap;
                        o_ot_valid <= 1'b1;
                        dup        <= 1'b0;
                    end
                end
                ROW_B: begin
                    if (ot_hs) begin
                        if (!dup) begin
                            dup <= 1'b1;
                        end else if (last_col) begin
                            col        <= '0;
                            dup        <= 1'b0;
                            o_ot_valid <= 1'b0;
                            state      <= ROW_A;
                            if (last_row) begin
                                row          <= '0;
                                o_frame_done <= 1'b1;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col       <= col_inc;
                            dup       <= 1'b0;
                            o_ot_fmap <= buf_next;
                        end
                    end
                end
                default: state <= ROW_A;
            endcase
        end
    end

endmodule

// File: tb/tb_stage2_unpooling_core.sv
// Self-checking bench for stage2_unpooling_core: a small 2x2 instance and a default 12x12 instance.
// Expected streams come from the 2x2 block mapping (zero-insertion when ST2_UNPOOL_ZERO_FILL_EN).
module tb_stage2_unpooling_core;

    localparam int CI = 3;
    localparam int BW = 19;
    localparam int FW = CI * BW;
    localparam int SW = 2;
    localparam int SH = 2;
    localparam int LW = 12;
    localparam int LH = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          sel;
    logic          in_valid;
    logic          ot_ready;
    logic [FW-1:0] in_fmap;

    logic          s_in_ready, s_ot_valid, s_done;
    logic [FW-1:0] s_ot_fmap;
    logic          l_in_ready, l_ot_valid, l_done;
    logic [FW-1:0] l_ot_fmap;

    logic          in_ready, ot_valid, done;
    logic [FW-1:0] ot_fmap;

    logic [FW-1:0] src_q[$];
    logic [FW-1:0] exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stage2_unpooling_core #(.ST2_CI(CI), .ST2_IBW(BW), .IN_W(SW), .IN_H(SH)) dut_s (
        .clk          (clk),
        .reset        (rst),
        .i_in_valid   (in_valid && !sel),
        .o_in_ready   (s_in_ready),
        .i_in_fmap    (in_fmap),
        .o_ot_valid   (s_ot_valid),
        .i_ot_ready   (ot_ready && !sel),
        .o_ot_fmap    (s_ot_fmap),
        .o_frame_done (s_done)
    );

    stage2_unpooling_core #(.ST2_CI(CI), .ST2_IBW(BW), .IN_W(LW), .IN_H(LH)) dut_l (
        .clk          (clk),
        .reset        (rst),
        .i_in_valid   (in_valid && sel),
        .o_in_ready   (l_in_ready),
        .i_in_fmap    (in_fmap),
        .o_ot_valid   (l_ot_valid),
        .i_ot_ready   (ot_ready && sel),
        .o_ot_fmap    (l_ot_fmap),
        .o_frame_done (l_done)
    );

    assign in_ready = sel ? l_in_ready : s_in_ready;
    assign ot_valid = sel ? l_ot_valid : s_ot_valid;
    assign ot_fmap  = sel ? l_ot_fmap  : s_ot_fmap;
    assign done     = sel ? l_done     : s_done;

    function automatic logic [FW-1:0] rand_point();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[FW-1:0];
    endfunction

    // Output k of a frame sits at (k / 2W, k % 2W) and maps back to input (row/2, col/2).
    task automatic build_exp(input int nframes);
        int w = sel ? LW : SW;
        int h = sel ? LH : SH;
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            for (int k = 0; k < 4 * w * h; k++) begin
                int orow = k / (2 * w);
                int ocol = k % (2 * w);
                logic [FW-1:0] v;
                v = src_q[f * w * h + (orow / 2) * w + ocol / 2];
`ifdef ST2_UNPOOL_ZERO_FILL_EN
                if ((orow % 2) != 0 || (ocol % 2) != 0) v = '0;
`endif
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        in_valid = 1'b0;
        ot_ready = 1'b0;
        in_fmap  = '0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Streams src_q through the selected instance, checking data order, stall stability,
    // ROW_B input back-pressure and frame_done timing; stop_after>0 ends after that many outputs.
    task automatic run_stream(input string name, input int rmode, input int vmode,
                              input int stop_after);
        int w = sel ? LW : SW;
        int h = sel ? LH : SH;
        int fpts = 4 * w * h;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int total_out = exp_q.size();
        int lim = (stop_after > 0) ? stop_after : total_out;
        logic done_next = 1'b0;
        logic prev_stall = 1'b0;
        logic acc = 1'b0;
        logic hs;
        logic [FW-1:0] prev_data = '0;
        in_valid = 1'b0;
        while ((got < lim || done_next) && cyc < 20 * total_out + 100) begin
            @(negedge clk);
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
            if (!in_valid && sent < src_q.size())
                in_valid = (vmode == 0) || ($urandom_range(0, 1) == 1);
            in_fmap  = (sent < src_q.size()) ? src_q[sent] : '0;
            ot_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0)
                                                          : ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (done !== done_next) begin
                bad++;
                $display("FAIL %s frame_done cyc=%0d: got %b expected %b", name, cyc, done,
                         done_next);
            end
            if (prev_stall) begin
                total++;
                if (ot_valid !== 1'b1 || ot_fmap !== prev_data) begin
                    bad++;
                    $display("FAIL %s stall_hold cyc=%0d: got v=%b %h expected v=1 %h", name,
                             cyc, ot_valid, ot_fmap, prev_data);
                end
            end
            if (got < total_out && ((got % fpts) / (2 * w)) % 2 == 1) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s row_b_in_ready cyc=%0d: got %b expected 0", name, cyc,
                             in_ready);
                end
            end
            hs  = ot_valid && ot_ready;
            acc = in_valid && in_ready;
            done_next = 1'b0;
            if (hs) begin
                total++;
                if (got >= total_out || ot_fmap !== exp_q[got]) begin
                    bad++;
                    $display("FAIL %s data[%0d]: got %h expected %h", name, got, ot_fmap,
                             (got < total_out) ? exp_q[got] : '0);
                end
                got++;
                done_next = (got % fpts == 0) && (stop_after == 0);
            end
            prev_stall = ot_valid && !ot_ready;
            prev_data  = ot_fmap;
            cyc++;
        end
        total++;
        if (got != lim) begin
            bad++;
            $display("FAIL %s output_count: got %0d expected %0d", name, got, lim);
        end
        in_valid = 1'b0;
    endtask

    task automatic load_abcd();
        src_q.delete();
        for (int i = 0; i < 4; i++) src_q.push_back(FW'(i + 1));
    endtask

    task automatic test_reset();
        sel = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        ot_ready = 1'b0;
        rst      = 1'b1;
        #1;
        total += 4;
        if (ot_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", ot_valid); end
        if (ot_fmap !== '0) begin bad++; $display("FAIL reset_fmap: got %h expected 0", ot_fmap); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        sel = 1'b0;
        apply_reset();
        load_abcd();
        build_exp(1);
        run_stream("basic", 0, 0, 0);
    endtask

    task automatic test_stall();
        sel = 1'b0;
        apply_reset();
        load_abcd();
        build_exp(1);
        run_stream("stall", 1, 0, 0);
    endtask

    task automatic test_packing();
        sel = 1'b0;
        apply_reset();
        src_q.delete();
        src_q.push_back({19'h7FFFF, 19'h40000, 19'h00001});
        src_q.push_back({19'h00001, 19'h7FFFF, 19'h40000});
        src_q.push_back({19'h40000, 19'h00001, 19'h7FFFF});
        src_q.push_back({19'h7FFFF, 19'h7FFFF, 19'h7FFFF});
        build_exp(1);
        run_stream("packing", 0, 0, 0);
    endtask

    task automatic test_random();
        sel = 1'b0;
        apply_reset();
        src_q.delete();
        for (int i = 0; i < 3 * SW * SH; i++) src_q.push_back(rand_point());
        build_exp(3);
        run_stream("random", 2, 1, 0);
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        apply_reset();
        load_abcd();
        build_exp(1);
        run_stream("mid_pre", 0, 0, 5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total += 3;
        if (ot_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b expected 0", ot_valid); end
        if (ot_fmap !== '0) begin bad++; $display("FAIL mid_reset_fmap: got %h expected 0", ot_fmap); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_reset_in_ready: got %b expected 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        src_q.delete();
        for (int i = 0; i < 4; i++) src_q.push_back(FW'(32'h100 + i));
        build_exp(1);
        run_stream("mid_post", 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        sel = 1'b1;
        apply_reset();
        src_q.delete();
        for (int i = 0; i < 2 * LW * LH; i++) src_q.push_back(rand_point());
        build_exp(2);
        run_stream("large_b2b", 0, 0, 0);
        sel = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        sel      = 1'b0;
        in_valid = 1'b0;
        ot_ready = 1'b0;
        in_fmap  = '0;
        test_reset();
        test_basic();
        test_stall();
        test_packing();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
